// File: rtl/input_conditioner_pkg.sv
// Shared constants and debounce FSM state encoding for the input conditioner.
package input_conditioner_pkg;
    localparam int NUM_CH = 4;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_e;
endpackage

// File: rtl/debounce_channel.sv
// One switch channel: metastability synchronizer, debounce counter FSM and
// single-cycle rise/fall pulses aligned with the clean level update.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic accept
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    db_state_e              state_q, state_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (synced != clean_q) begin
            // Holding off while a pulse is out keeps pulses from landing on
            // consecutive cycles when DEBOUNCE_CYCLES is 1.
            if (cnt_q == CNT_LAST && !(rise_q || fall_q)) begin
                clean_d = synced;
                cnt_d   = '0;
                state_d = ST_STABLE;
                rise_d  = synced;
                fall_d  = !synced;
            end else if (cnt_q != CNT_LAST) begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ST_PENDING;
            end else begin
                state_d = ST_PENDING;
            end
        end else begin
            cnt_d   = '0;
            state_d = ST_STABLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_STABLE;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean  = clean_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign accept = rise_d | fall_d;
endmodule

// File: rtl/input_conditioner.sv
// Four independent debounced switch channels plus a registered any-edge flag
// that asserts in the same cycle as the per-channel pulses.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] sw_in,
    output logic [NUM_CH-1:0] sw_clean,
    output logic [NUM_CH-1:0] sw_rise,
    output logic [NUM_CH-1:0] sw_fall,
    output logic              changed
);
    logic [NUM_CH-1:0] accept;
    logic              changed_q, changed_d;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .raw_in(sw_in[ch]),
            .clean (sw_clean[ch]),
            .rise  (sw_rise[ch]),
            .fall  (sw_fall[ch]),
            .accept(accept[ch])
        );
    end

    // Built from the channels' next-cycle pulses so the flag lands with them.
    assign changed_d = |accept;

    always_ff @(posedge clk) begin
        if (!rst_n) changed_q <= 1'b0;
        else        changed_q <= changed_d;
    end

    assign changed = changed_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_input_conditioner;
    logic       clk;
    logic       rst_n;
    logic [3:0] sw_in;
    logic [3:0] sw_clean;
    logic [3:0] sw_rise;
    logic [3:0] sw_fall;
    logic       changed;

    int total;
    int bad;

    input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_in   (sw_in),
        .sw_clean(sw_clean),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .changed (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw_in = 4'b0000;
        step();
        step();
        total++;
        if (sw_clean !== 4'b0000 || sw_rise !== 4'b0000 || sw_fall !== 4'b0000 || changed !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: clean=%b rise=%b fall=%b changed=%b required all zero",
                     sw_clean, sw_rise, sw_fall, changed);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (sw_clean !== 4'b0000 || sw_rise !== 4'b0000 || sw_fall !== 4'b0000 || changed !== 1'b0) begin
                bad++;
                $display("FAIL idle_zero cyc%0d: clean=%b rise=%b fall=%b changed=%b required all zero",
                         i, sw_clean, sw_rise, sw_fall, changed);
            end
        end
    endtask

    task automatic test_single_rise();
        sw_in = 4'b0001;
        for (int i = 1; i <= 9; i++) begin
            step();
            total++;
            if (sw_clean !== ((i >= 6) ? 4'b0001 : 4'b0000) ||
                sw_rise  !== ((i == 6) ? 4'b0001 : 4'b0000) ||
                sw_fall  !== 4'b0000 || changed !== (i == 6)) begin
                bad++;
                $display("FAIL single_rise edge%0d: clean=%b rise=%b fall=%b changed=%b required clean=%b rise=%b changed=%b",
                         i, sw_clean, sw_rise, sw_fall, changed,
                         (i >= 6) ? 4'b0001 : 4'b0000, (i == 6) ? 4'b0001 : 4'b0000, (i == 6));
            end
        end
    endtask

    task automatic test_bounce();
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                sw_in = (k < 3) ? 4'b0011 : 4'b0001;
                step();
                total++;
                if (sw_clean !== 4'b0001 || sw_rise !== 4'b0000 || sw_fall !== 4'b0000 || changed !== 1'b0) begin
                    bad++;
                    $display("FAIL bounce r%0d k%0d: clean=%b rise=%b fall=%b changed=%b required clean=0001 no pulses",
                             r, k, sw_clean, sw_rise, sw_fall, changed);
                end
            end
        end
        sw_in = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (sw_clean !== 4'b0001 || sw_rise !== 4'b0000 || sw_fall !== 4'b0000 || changed !== 1'b0) begin
                bad++;
                $display("FAIL bounce_settle cyc%0d: clean=%b rise=%b fall=%b changed=%b required clean=0001 no pulses",
                         i, sw_clean, sw_rise, sw_fall, changed);
            end
        end
    endtask

    task automatic test_all_rise();
        rst_n = 1'b0;
        sw_in = 4'b0000;
        step();
        rst_n = 1'b1;
        step();
        step();
        sw_in = 4'b1111;
        for (int i = 1; i <= 9; i++) begin
            step();
            total++;
            if (sw_clean !== ((i >= 6) ? 4'b1111 : 4'b0000) ||
                sw_rise  !== ((i == 6) ? 4'b1111 : 4'b0000) ||
                sw_fall  !== 4'b0000 || changed !== (i == 6)) begin
                bad++;
                $display("FAIL all_rise edge%0d: clean=%b rise=%b fall=%b changed=%b required clean=%b rise=%b changed=%b",
                         i, sw_clean, sw_rise, sw_fall, changed,
                         (i >= 6) ? 4'b1111 : 4'b0000, (i == 6) ? 4'b1111 : 4'b0000, (i == 6));
            end
        end
    endtask

    task automatic test_fall();
        sw_in = 4'b0111;
        for (int i = 1; i <= 9; i++) begin
            step();
            total++;
            if (sw_clean !== ((i >= 6) ? 4'b0111 : 4'b1111) ||
                sw_fall  !== ((i == 6) ? 4'b1000 : 4'b0000) ||
                sw_rise  !== 4'b0000 || changed !== (i == 6)) begin
                bad++;
                $display("FAIL fall_d edge%0d: clean=%b rise=%b fall=%b changed=%b required clean=%b fall=%b changed=%b",
                         i, sw_clean, sw_rise, sw_fall, changed,
                         (i >= 6) ? 4'b0111 : 4'b1111, (i == 6) ? 4'b1000 : 4'b0000, (i == 6));
            end
        end
    endtask

    task automatic test_reset_pending();
        rst_n = 1'b0;
        sw_in = 4'b0000;
        step();
        rst_n = 1'b1;
        step();
        step();
        sw_in = 4'b0100;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        total++;
        if (sw_clean !== 4'b0000 || sw_rise !== 4'b0000 || sw_fall !== 4'b0000 || changed !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_pending: clean=%b rise=%b fall=%b changed=%b required all zero",
                     sw_clean, sw_rise, sw_fall, changed);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            total++;
            if (sw_clean !== ((i >= 6) ? 4'b0100 : 4'b0000) ||
                sw_rise  !== ((i == 6) ? 4'b0100 : 4'b0000) ||
                sw_fall  !== 4'b0000 || changed !== (i == 6)) begin
                bad++;
                $display("FAIL post_reset_rise edge%0d: clean=%b rise=%b fall=%b changed=%b required clean=%b rise=%b changed=%b",
                         i, sw_clean, sw_rise, sw_fall, changed,
                         (i >= 6) ? 4'b0100 : 4'b0000, (i == 6) ? 4'b0100 : 4'b0000, (i == 6));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        sw_in = 4'b0000;
        test_reset();
        test_single_rise();
        test_bounce();
        test_all_rise();
        test_fall();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive cycles a synchronized level must differ from the clean level before it is accepted (10 ms at 100 MHz); legal range >= 1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, depth of the metastability synchronizer chain per channel; legal range >= 2.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all flops SHALL be rising-edge clk.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port sw_in, input, 4 bits: raw asynchronous switch/button levels; bit0 = a, bit1 = b, bit2 = c, bit3 = d.
REQ-006 SHALL have port sw_clean, output, 4 bits: debounced, synchronized levels in the same bit order; these drive the a/b/c/d inputs of the downstream gate-level logic.
REQ-007 SHALL have port sw_rise, output, 4 bits: one-cycle pulse per channel when sw_clean bit goes 0->1.
REQ-008 SHALL have port sw_fall, output, 4 bits: one-cycle pulse per channel when sw_clean bit goes 1->0.
REQ-009 SHALL have port changed, output, 1 bit: OR of all sw_rise and sw_fall bits, registered in the same cycle as the pulses.

Function
REQ-010 Each channel SHALL pass sw_in through SYNC_STAGES flops; only the last stage (synced) feeds debounce logic.
REQ-011 Each channel SHALL implement a two-state FSM: STABLE (synced == sw_clean, counter = 0) and PENDING (synced != sw_clean, counter counting).
REQ-012 STABLE -> PENDING when synced != sw_clean; counter increments each cycle in PENDING while synced != sw_clean.
REQ-013 PENDING -> STABLE with counter cleared, sw_clean unchanged, when synced returns equal to sw_clean before the count completes (bounce restarts the count from 0).
REQ-014 PENDING -> STABLE when synced has differed for DEBOUNCE_CYCLES consecutive cycles: on that edge sw_clean takes synced, counter clears, and the matching sw_rise/sw_fall bit is 1 for exactly that one following cycle.
REQ-015 Latency: sw_clean SHALL update on the (SYNC_STAGES + DEBOUNCE_CYCLES)-th rising edge, counting the first edge that samples the new stable level as edge 1; pulses coincide with the sw_clean update.
REQ-016 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); counter SHALL never exceed DEBOUNCE_CYCLES (no wrap-around).
REQ-017 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce simultaneous updates and pulses.
REQ-018 DEBOUNCE_CYCLES = 1 SHALL accept a change after one cycle of difference, with no other behavioural change.
REQ-019 Pulses SHALL never be asserted for two consecutive cycles on the same channel; sw_rise and sw_fall SHALL never both be 1 on the same bit.

Reset
REQ-020 While rst_n = 0 at a rising clk edge: all synchronizer flops, counters, sw_clean, sw_rise, sw_fall, changed SHALL become 0 and all FSMs STABLE.
REQ-021 Reset mid-PENDING SHALL discard the partial count; after release a level held at 1 SHALL be accepted after full latency per REQ-015 and generate sw_rise.

Structure
REQ-022 A shared package input_conditioner_pkg SHALL hold NUM_CH = 4 and the STABLE/PENDING state encoding.
REQ-023 Per-channel logic (synchronizer, counter, FSM, edge pulses) SHALL be sub-module debounce_channel, instantiated NUM_CH times; top level only concatenates outputs and forms changed.

Verification (DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2)
REQ-024 Reset, sw_in = 4'b0000 for 20 cycles -> sw_clean = 0000, sw_rise = sw_fall = 0000, changed = 0 throughout.
REQ-025 sw_in[0] 0->1 and held -> sw_clean[0] = 1 on 6th edge after first sampling edge; sw_rise = 0001 and changed = 1 for exactly one cycle.
REQ-026 sw_in[1] high 3 cycles, low 1, repeated 5 times, then low -> sw_clean[1] stays 0, no pulses.
REQ-027 sw_in 0000 -> 1111 in one cycle -> sw_clean = 1111 and sw_rise = 1111 on same cycle, single-cycle pulse.
REQ-028 From sw_clean = 1111, sw_in[3] -> 0 -> sw_fall = 1000 one cycle, sw_clean = 0111 after 6 edges.
REQ-029 sw_in[2] high 4 cycles, rst_n low 1 cycle, sw_in[2] held high -> all outputs 0 during reset; sw_clean[2] = 1 with sw_rise[2] pulse 6 edges after rst_n release.
